// File: rtl/fetch_if.sv
// Fetch-stage bundle: pipeline control in, instruction memory request/response, decoder outputs.
// Latency: none, signal container only.
// Backpressure: IMemReq is the only flow-control signal; responses cannot be throttled.
interface fetch_if;
    logic        Stall;
    logic        DivStall;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemValid;
    logic [15:0] IMemData;
    logic [15:0] Instruct;
    logic [15:0] InstrPC;
    logic        InstrValid;

    // Fetch unit side
    modport master (
        input  Stall, DivStall, Redirect, RedirectPC, IMemValid, IMemData,
        output IMemReq, IMemAddr, Instruct, InstrPC, InstrValid
    );

    // Pipeline control / instruction memory side
    modport slave (
        output Stall, DivStall, Redirect, RedirectPC, IMemValid, IMemData,
        input  IMemReq, IMemAddr, Instruct, InstrPC, InstrValid
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one request at a time, buffers words and feeds the decoder.
// Latency: IMemValid -> Instruct is at least 2 cycles (words always pass through the buffer).
// Backpressure: Stall|DivStall freezes the output register; IMemReq drops while the buffer is full.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd2,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] NOP        = 16'b1110100000000000
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state;
    logic [15:0]   pc;

    logic [15:0]   fifo_dat [FIFO_DEPTH];
    logic [15:0]   fifo_pc  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic hold;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign hold       = bus.Stall | bus.DivStall;
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Request is Mealy on Redirect so a redirect cycle never launches a fetch of the stale PC.
    // Only issued with a free slot, so buffered + outstanding words never exceed the depth.
    assign bus.IMemReq  = rst && (state == REQ) && !bus.Redirect && !fifo_full;
    assign bus.IMemAddr = pc;

    // A response is captured only in WAIT; a redirect in the same cycle kills it.
    assign push = (state == WAIT) && bus.IMemValid && !bus.Redirect;
    assign pop  = !bus.Redirect && !hold && !fifo_empty;

    // Request sequencer and PC; redirect overrides the PC last so it always wins.
    // A response landing in DROP together with a second redirect still retires the abandoned
    // request, otherwise the sequencer would wait forever for a reply that never comes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ:  if (bus.IMemReq) state <= WAIT;
                WAIT: begin
                    if (bus.IMemValid) begin
                        state <= REQ;
                        pc    <= pc + PC_STEP;
                    end else if (bus.Redirect) begin
                        state <= DROP;
                    end
                end
                DROP: if (bus.IMemValid) state <= REQ;
                default: state <= IDLE;
            endcase
            if (bus.Redirect) pc <= bus.RedirectPC;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst || bus.Redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Buffer storage: word and the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr] <= bus.IMemData;
            fifo_pc[wr_ptr]  <= pc;
        end
    end

    // Decoder-facing register: redirect bubbles, hold freezes, otherwise pop or insert NOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.Instruct   <= NOP;
            bus.InstrPC    <= 16'h0000;
            bus.InstrValid <= 1'b0;
        end else if (bus.Redirect) begin
            bus.Instruct   <= NOP;
            bus.InstrValid <= 1'b0;
        end else if (!hold) begin
            if (!fifo_empty) begin
                bus.Instruct   <= fifo_dat[rd_ptr];
                bus.InstrPC    <= fifo_pc[rd_ptr];
                bus.InstrValid <= 1'b1;
            end else begin
                bus.Instruct   <= NOP;
                bus.InstrValid <= 1'b0;
            end
        end
    end

    // The request gating makes a push into a full buffer unreachable.
    always_ff @(posedge clk) begin
        if (rst) assert (!(push && fifo_full));
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus a randomized phase against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;
    localparam logic [15:0] NOP_W = 16'b1110100000000000;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if u_if ();
    fetch_if v_if ();

    fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2), .FIFO_DEPTH(DEPTH), .NOP(NOP_W))
        u_dut (.clk(clk), .rst(rst), .bus(u_if.master));
    fetch_unit #(.RESET_PC(16'hFFFE), .PC_STEP(16'd2), .FIFO_DEPTH(DEPTH), .NOP(NOP_W))
        u_wrap (.clk(clk), .rst(rst), .bus(v_if.master));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- instruction memory models ----------------
    int  lat      = 1;
    bit  rand_lat = 1'b0;

    initial begin
        logic        req_s;
        logic [15:0] addr_s;
        logic [15:0] pend_addr;
        int          cnt;
        cnt = 0;
        pend_addr = 16'h0;
        u_if.IMemValid = 1'b0;
        u_if.IMemData  = 16'h0;
        forever begin
            @(negedge clk);
            req_s  = u_if.IMemReq;
            addr_s = u_if.IMemAddr;
            @(posedge clk);
            #1;
            u_if.IMemValid = 1'b0;
            if (req_s === 1'b1) begin
                pend_addr = addr_s;
                cnt = rand_lat ? int'($urandom_range(1, 4)) : lat;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    u_if.IMemValid = 1'b1;
                    u_if.IMemData  = 16'(pend_addr + 16'h1000);
                end
            end
        end
    end

    initial begin
        logic        req_s;
        logic [15:0] addr_s;
        v_if.IMemValid = 1'b0;
        v_if.IMemData  = 16'h0;
        forever begin
            @(negedge clk);
            req_s  = v_if.IMemReq;
            addr_s = v_if.IMemAddr;
            @(posedge clk);
            #1;
            v_if.IMemValid = 1'b0;
            if (req_s === 1'b1) begin
                v_if.IMemValid = 1'b1;
                v_if.IMemData  = 16'(addr_s + 16'h1000);
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] pc;
        int          edge_no;
    } ent_t;

    ent_t        q[$];
    int          cyc          = 0;
    bit          outstanding  = 1'b0;
    bit          live         = 1'b0;
    bit          idle_pending = 1'b1;
    bit          just_acc     = 1'b0;
    logic [15:0] live_pc      = 16'h0;
    logic [15:0] exp_fetch    = 16'h0;
    logic [15:0] exp_instr    = NOP_W;
    logic [15:0] exp_pc       = 16'h0;
    logic        exp_valid    = 1'b0;

    logic [15:0] exp2_fetch = 16'hFFFE;
    logic [15:0] exp2_pc    = 16'hFFFE;
    bit          seen_top   = 1'b0;
    bit          wrapped2   = 1'b0;

    task automatic step();
        logic        s_rst, s_req, s_valid, s_hold, s_redir, s2_req;
        logic [15:0] s_addr, s_rpc, s2_addr;
        logic        e_req;

        @(negedge clk);
        s_rst   = rst;
        s_req   = u_if.IMemReq;
        s_addr  = u_if.IMemAddr;
        s_valid = u_if.IMemValid;
        s_hold  = u_if.Stall | u_if.DivStall;
        s_redir = u_if.Redirect;
        s_rpc   = u_if.RedirectPC;
        s2_req  = v_if.IMemReq;
        s2_addr = v_if.IMemAddr;

        // A fetch is due whenever nothing is in flight, no redirect, and the buffer has room.
        e_req = s_rst && !idle_pending && !outstanding && !s_redir && (q.size() < DEPTH);
        chk("imemreq", s_req, e_req);
        if (s_req === 1'b1) chk("imemaddr", s_addr, exp_fetch);
        if (s2_req === 1'b1) chk("u2_addr", s2_addr, exp2_fetch);

        @(posedge clk);
        #2;
        cyc++;
        just_acc = 1'b0;

        if (!s_rst) begin
            q.delete();
            outstanding  = 1'b0;
            live         = 1'b0;
            idle_pending = 1'b1;
            exp_fetch    = 16'h0000;
            exp_instr    = NOP_W;
            exp_pc       = 16'h0000;
            exp_valid    = 1'b0;
            exp2_fetch   = 16'hFFFE;
            exp2_pc      = 16'hFFFE;
        end else begin
            idle_pending = 1'b0;
            // decoder register
            if (s_redir) begin
                exp_instr = NOP_W;
                exp_valid = 1'b0;
            end else if (!s_hold) begin
                if (q.size() > 0 && q[0].edge_no < cyc) begin
                    exp_pc    = q[0].pc;
                    exp_instr = 16'(q[0].pc + 16'h1000);
                    exp_valid = 1'b1;
                    void'(q.pop_front());
                end else begin
                    exp_instr = NOP_W;
                    exp_valid = 1'b0;
                end
            end
            // response retires the single in-flight request
            if (s_valid === 1'b1 && outstanding) begin
                if (live && !s_redir) begin
                    q.push_back('{pc: live_pc, edge_no: cyc});
                    exp_fetch = 16'(live_pc + 16'd2);
                end
                outstanding = 1'b0;
                live        = 1'b0;
            end
            if (s_redir) begin
                q.delete();
                exp_fetch = s_rpc;
                live      = 1'b0;
            end
            if (s_req === 1'b1) begin
                outstanding = 1'b1;
                live        = 1'b1;
                live_pc     = exp_fetch;
                just_acc    = 1'b1;
            end
            // wrap instance: contiguous stream from FFFE
            if (s2_req === 1'b1) exp2_fetch = 16'(exp2_fetch + 16'd2);
            if (v_if.InstrValid === 1'b1) begin
                chk("u2_instr", v_if.Instruct, 16'(exp2_pc + 16'h1000));
                chk("u2_pc", v_if.InstrPC, exp2_pc);
                if (v_if.InstrPC === 16'hFFFE) seen_top = 1'b1;
                else if (v_if.InstrPC === 16'h0000 && seen_top) wrapped2 = 1'b1;
                exp2_pc = 16'(exp2_pc + 16'd2);
            end
        end

        chk("instruct", u_if.Instruct, exp_instr);
        chk("instrpc", u_if.InstrPC, exp_pc);
        chk("instrvalid", u_if.InstrValid, exp_valid);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;

        rst = 1'b0;
        u_if.Stall = 1'b0; u_if.DivStall = 1'b0; u_if.Redirect = 1'b0; u_if.RedirectPC = 16'h0;
        v_if.Stall = 1'b0; v_if.DivStall = 1'b0; v_if.Redirect = 1'b0; v_if.RedirectPC = 16'h0;

        // reset, then free-running stream with 1-cycle memory
        repeat (3) step();
        chk("reset_req", u_if.IMemReq, 1'b0);
        rst = 1'b1;
        repeat (20) step();

        // freeze while streaming: buffer fills, request stops
        u_if.Stall = 1'b1;
        repeat (6) step();
        chk("req_low_full", u_if.IMemReq, 1'b0);
        u_if.Stall = 1'b0;
        repeat (8) step();
        u_if.DivStall = 1'b1;
        repeat (3) step();
        u_if.DivStall = 1'b0;
        repeat (8) step();

        // redirect while the fetch of 0x0006 is in flight (3-cycle memory)
        rst = 1'b0;
        step();
        rst = 1'b1;
        lat = 3;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (just_acc && live_pc == 16'h0006) found = 1'b1;
        end
        chk("reach_0006", found, 1'b1);
        u_if.Redirect = 1'b1; u_if.RedirectPC = 16'h0040;
        step();
        u_if.Redirect = 1'b0;
        chk("redir_nop", u_if.Instruct, NOP_W);
        chk("redir_nop_vld", u_if.InstrValid, 1'b0);
        repeat (15) step();

        // redirect coinciding with a response
        lat = 2;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (u_if.IMemValid === 1'b1) found = 1'b1;
        end
        chk("reach_valid", found, 1'b1);
        u_if.Redirect = 1'b1; u_if.RedirectPC = 16'h0100;
        step();
        u_if.Redirect = 1'b0;
        chk("redir2_nop", u_if.Instruct, NOP_W);
        repeat (12) step();

        // randomized holds, redirects and memory latency
        rand_lat = 1'b1;
        for (int k = 0; k < 400; k++) begin
            u_if.Stall      = ($urandom_range(0, 3) == 0);
            u_if.DivStall   = ($urandom_range(0, 7) == 0);
            u_if.Redirect   = ($urandom_range(0, 24) == 0);
            u_if.RedirectPC = 16'($urandom) & 16'hFFFE;
            step();
        end
        u_if.Stall = 1'b0; u_if.DivStall = 1'b0; u_if.Redirect = 1'b0;
        rand_lat = 1'b0;
        repeat (10) step();

        // reset while waiting; the late response lands while the unit is idle
        lat = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (just_acc) found = 1'b1;
        end
        chk("reach_wait", found, 1'b1);
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (20) step();

        chk("u2_wrap", wrapped2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
